// File: rtl/max_pool_stream_pkg.sv
// Shared definitions for the conv2d / max-pool streaming datapath:
// default lane geometry and the pooling window state encoding.
package max_pool_stream_pkg;

    localparam int NUM_FILTERS_DEF = 32;
    localparam int DATA_WIDTH_DEF  = 16;
    localparam int LANE_W          = DATA_WIDTH_DEF;

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } pool_state_e;

    function automatic int lane_lsb(input int f, input int w);
        return f * w;
    endfunction

endpackage

// File: rtl/max_pool_stream_max_lane.sv
// Unsigned two-input maximum for one activation lane.
module max_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] max_o
);

    assign max_o = (a_i >= b_i) ? a_i : b_i;

endmodule

// File: rtl/max_pool_stream.sv
// Streaming 1-D max pool over conv2d output columns, stride = window.
// Single registered output stage with pass-through ready.
module max_pool_stream
    import max_pool_stream_pkg::*;
#(
    parameter int NUM_FILTERS = NUM_FILTERS_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int POOL_SIZE   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_FILTERS*DATA_WIDTH-1:0] in_data,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    output logic [NUM_FILTERS*DATA_WIDTH-1:0] out_data,
    output logic                            out_valid,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic [15:0]                     frames_done
);

    localparam int W  = NUM_FILTERS * DATA_WIDTH;
    localparam int CW = $clog2(POOL_SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(POOL_SIZE - 1);

    pool_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  out_data_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic [15:0]   frames_q;

    logic          accept;
    logic          closing;
    logic [W-1:0]  max_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // cnt_q is zero in EMPTY, so a lone beat only closes on in_last
    assign closing  = accept && (in_last || cnt_q == CNT_LAST);

    for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_lane
        localparam int LSB = lane_lsb(f, DATA_WIDTH);
        logic [DATA_WIDTH-1:0] base;

        assign base = (state_q == ACCUM) ? acc_q[LSB +: DATA_WIDTH]
                                         : in_data[LSB +: DATA_WIDTH];

        max_lane #(.DATA_WIDTH(DATA_WIDTH)) u_max (
            .a_i  (base),
            .b_i  (in_data[LSB +: DATA_WIDTH]),
            .max_o(max_d[LSB +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frames_q    <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                if (out_last_q) frames_q <= frames_q + 16'd1;
            end
            if (closing) begin
                out_data_q  <= max_d;
                out_last_q  <= in_last;
                out_valid_q <= 1'b1;
                cnt_q       <= '0;
                state_q     <= EMPTY;
            end else if (accept) begin
                acc_q   <= max_d;
                cnt_q   <= cnt_q + CW'(1);
                state_q <= ACCUM;
            end
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign frames_done = frames_q;

endmodule

// File: tb/tb_max_pool_stream.sv
// Directed bench for max_pool_stream with a window-queue reference model.
module tb_max_pool_stream;

    localparam int NF = 32;
    localparam int DW = 16;
    localparam int P  = 2;
    localparam int W  = NF * DW;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic [15:0]  frames_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] win[$];
    beat_t        exp_q[$];
    beat_t        obs[$];
    beat_t        e;
    int           m_frames = 0;
    logic         stall_q = 1'b0;
    logic [W-1:0] hold_d;
    logic         hold_l;
    int           ready_low = 0;

    max_pool_stream #(
        .NUM_FILTERS(NF),
        .DATA_WIDTH (DW),
        .POOL_SIZE  (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] bt(input int v0, input int v1);
        logic [W-1:0] r;
        r = '0;
        r[0 +: DW]  = DW'(v0);
        r[DW +: DW] = DW'(v1);
        return r;
    endfunction

    function automatic logic [DW-1:0] lane(input logic [W-1:0] v, input int f);
        return v[f*DW +: DW];
    endfunction

    // Reference: collect each window's beats, emit their lane-wise max.
    always @(negedge clk) begin
        if (rst) begin
            win.delete();
            exp_q.delete();
            m_frames = 0;
            stall_q  = 1'b0;
        end else begin
            chk("in_ready_rule", W'(in_ready), W'(!out_valid || out_ready));
            chk("frames_done", W'(frames_done), W'(m_frames));
            if (stall_q) begin
                chk("hold_valid", W'(out_valid), W'(1));
                chk("hold_data", out_data, hold_d);
                chk("hold_last", W'(out_last), W'(hold_l));
            end
            stall_q = out_valid && !out_ready;
            hold_d  = out_data;
            hold_l  = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got %0h expected none",
                             out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", W'(out_last), W'(e.l));
                    if (e.l) m_frames = (m_frames + 1) % 65536;
                    obs.push_back('{d: out_data, l: out_last});
                end
            end
            if (in_valid && !in_ready) ready_low++;
            if (in_valid && in_ready) begin
                win.push_back(in_data);
                if (in_last || win.size() == P) begin
                    beat_t nb;
                    nb.d = '0;
                    nb.l = in_last;
                    for (int f = 0; f < NF; f++)
                        foreach (win[k])
                            if (lane(win[k], f) > nb.d[f*DW +: DW])
                                nb.d[f*DW +: DW] = lane(win[k], f);
                    exp_q.push_back(nb);
                    win.delete();
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic l);
        int t;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] va;
        logic [W-1:0] vb;
        int           lv[8];
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_frames", W'(frames_done), W'(0));
        chk("rst_out_data", out_data, '0);
        idle(2);
        rst       = 1'b0;
        out_ready = 1'b1;
        idle(1);

        // 5,9 then 3,1 -> 9, 3 one cycle after each closing beat
        obs.delete();
        send(bt(5, 1), 1'b0);
        send(bt(9, 0), 1'b0);
        chk("lat_valid0", W'(out_valid), W'(1));
        chk("lat_data0", W'(lane(out_data, 0)), W'(9));
        send(bt(3, 7), 1'b0);
        send(bt(1, 8), 1'b0);
        chk("lat_valid1", W'(out_valid), W'(1));
        chk("lat_data1", W'(lane(out_data, 0)), W'(3));
        idle(2);
        chk("pair_count", W'(obs.size()), W'(2));

        // 4,7,6(last) -> 7 then 6 with last
        obs.delete();
        send(bt(4, 0), 1'b0);
        send(bt(7, 0), 1'b0);
        send(bt(6, 0), 1'b1);
        idle(2);
        chk("tail_count", W'(obs.size()), W'(2));
        if (obs.size() == 2) begin
            chk("tail0_data", W'(lane(obs[0].d, 0)), W'(7));
            chk("tail0_last", W'(obs[0].l), W'(0));
            chk("tail1_data", W'(lane(obs[1].d, 0)), W'(6));
            chk("tail1_last", W'(obs[1].l), W'(1));
        end
        chk("tail_frames", W'(frames_done), W'(1));

        // lane f = f then 31-f, with one lane saturated
        obs.delete();
        va = '0;
        vb = '0;
        for (int f = 0; f < NF; f++) begin
            va[f*DW +: DW] = DW'(f);
            vb[f*DW +: DW] = DW'(31 - f);
        end
        vb[5*DW +: DW] = 16'hFFFF;
        send(va, 1'b0);
        send(vb, 1'b0);
        idle(2);
        chk("lanes_count", W'(obs.size()), W'(1));
        if (obs.size() == 1)
            for (int f = 0; f < NF; f++)
                chk($sformatf("lane%0d", f), W'(lane(obs[0].d, f)),
                    W'((f == 5) ? 16'hFFFF : ((f > 31 - f) ? f : 31 - f)));

        // back-to-back stream, 8 beats, never stalls
        obs.delete();
        ready_low = 0;
        lv = '{3, 8, 2, 2, 9, 1, 0, 65535};
        for (int i = 0; i < 8; i++) send(bt(lv[i], i), 1'b0);
        idle(2);
        chk("flow_ready_low", W'(ready_low), W'(0));
        chk("flow_count", W'(obs.size()), W'(4));
        if (obs.size() == 4) begin
            chk("flow0", W'(lane(obs[0].d, 0)), W'(8));
            chk("flow1", W'(lane(obs[1].d, 0)), W'(2));
            chk("flow2", W'(lane(obs[2].d, 0)), W'(9));
            chk("flow3", W'(lane(obs[3].d, 0)), W'(65535));
        end

        // consumer stall with a beat waiting at the input
        obs.delete();
        out_ready = 1'b0;
        send(bt(1, 0), 1'b0);
        send(bt(2, 0), 1'b0);
        in_data  = bt(3, 0);
        in_last  = 1'b0;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", W'(in_ready), W'(0));
            chk("stall_data", W'(lane(out_data, 0)), W'(2));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(bt(3, 0), 1'b0);
        send(bt(4, 0), 1'b1);
        idle(2);
        chk("stall_count", W'(obs.size()), W'(2));
        if (obs.size() == 2) begin
            chk("stall_o0", W'(lane(obs[0].d, 0)), W'(2));
            chk("stall_o1", W'(lane(obs[1].d, 0)), W'(4));
            chk("stall_o1_last", W'(obs[1].l), W'(1));
        end
        chk("stall_frames", W'(frames_done), W'(2));

        // reset mid-window drops the partial window
        send(bt(7, 0), 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_frames", W'(frames_done), W'(0));
        chk("arst_valid", W'(out_valid), W'(0));
        chk("arst_ready", W'(in_ready), W'(1));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs.delete();
        send(bt(2, 0), 1'b0);
        send(bt(8, 0), 1'b0);
        idle(3);
        chk("rst_win_count", W'(obs.size()), W'(1));
        if (obs.size() == 1)
            chk("rst_win_data", W'(lane(obs[0].d, 0)), W'(8));
        chk("model_drained", W'(exp_q.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/max_pool_stream.md
MAX_POOL_STREAM -- requirements
Module: max_pool_stream

Interface
REQ-001 SHALL have parameter NUM_FILTERS, default 32: lanes per beat, one per conv2d filter.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: unsigned activation width per lane.
REQ-003 SHALL have parameter POOL_SIZE, default 2: beats per pooling window; stride equals POOL_SIZE; legal range 2..16.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port in_data  input  NUM_FILTERS*DATA_WIDTH: one conv2d output column; lane f at bits [f*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port in_valid  input  1: in_data/in_last are valid.
REQ-008 SHALL have port in_last  input  1: beat is the final column of a frame.
REQ-009 SHALL have port in_ready  output  1: block accepts a beat this cycle.
REQ-010 SHALL have port out_data  output  NUM_FILTERS*DATA_WIDTH: pooled column, same lane packing.
REQ-011 SHALL have port out_valid  output  1: out_data/out_last are valid.
REQ-012 SHALL have port out_last  output  1: pooled column is the final one of its frame.
REQ-013 SHALL have port out_ready  input  1: consumer accepts the output beat.
REQ-014 SHALL have port frames_done  output  16: count of frames emitted (out_last beats accepted), wraps at 2^16.

Function
REQ-015 Beat accepted iff in_valid && in_ready; output beat transferred iff out_valid && out_ready.
REQ-016 in_ready = !out_valid || out_ready (combinational; single output register, no bubble under continuous flow).
REQ-017 State machine: EMPTY (no beats in window), ACCUM (1..POOL_SIZE-1 beats held); beat counter cnt tracks beats in window.
REQ-018 EMPTY, accepted beat, not closing: acc <= in_data lane-wise, cnt <= 1, -> ACCUM.
REQ-019 ACCUM, accepted beat, not closing: acc[f] <= max(acc[f], in_f) per lane (unsigned compare), cnt <= cnt+1.
REQ-020 Closing beat = accepted beat with cnt == POOL_SIZE-1 or in_last=1 (EMPTY treated as cnt=0).
REQ-021 On closing beat: out_data <= lane-wise max of acc (if ACCUM) and in_data, out_last <= in_last, out_valid <= 1, cnt <= 0, -> EMPTY; latency 1 cycle from closing beat to out_valid.
REQ-022 Partial window terminated by in_last SHALL emit max of the beats received (no zero padding); a single-beat final window passes in_data unchanged.
REQ-023 in_last on a beat that also fills the window SHALL produce one output with out_last=1, not two.
REQ-024 out_valid cleared after transfer unless a new closing beat is accepted the same cycle, in which case out_valid stays 1 with the new data.
REQ-025 out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-026 Non-closing beats SHALL be accepted while out_valid && !out_ready is false only; when in_ready=0 no state changes.
REQ-027 frames_done increments by 1 on each transfer with out_last=1.

Reset
REQ-028 rst asserted: out_valid=0, out_last=0, out_data=0, acc=0, cnt=0, frames_done=0, state EMPTY, immediately (asynchronous).
REQ-029 rst mid-window SHALL discard the partial window; first beat after release starts a new window.
REQ-030 in_ready SHALL be 1 during and after reset (output register empty).

Structure
REQ-031 Shared package holds default NUM_FILTERS, DATA_WIDTH, lane-slice helper constant and EMPTY/ACCUM state encoding, common with conv2d.
REQ-032 One sub-module max_lane (DATA_WIDTH-wide unsigned two-input max), instantiated NUM_FILTERS times.

Verification
REQ-033 POOL_SIZE=2, lane0 beats 5,9 then 3,1, out_ready=1 -> outputs lane0 9 then 3, each 1 cycle after second beat.
REQ-034 POOL_SIZE=2, three beats lane0 4,7,6 with in_last on third -> outputs 7 (out_last=0) then 6 (out_last=1); frames_done=1.
REQ-035 Continuous in_valid, out_ready=1, POOL_SIZE=2, 8 beats -> in_ready never low, 4 outputs, no bubbles.
REQ-036 out_ready held 0 for 5 cycles with output pending -> in_ready=0, out_data stable, no beat lost; release -> stream resumes in order.
REQ-037 Lanes with distinct values (lane f = f, then 31-f) -> out lane f = max(f,31-f) for all 32 lanes, including 0xFFFF in any lane.
REQ-038 rst pulsed after one beat of a window -> no output; next two beats 2,8 -> single output 8.
